// File: rtl/wb_request_initiator_pkg.sv
// wb_initiator_pkg: shared FSM state, request type and abort data for the Wishbone request initiator.
// The top's optional timeout abort is enabled by defining WB_TIMEOUT_EN.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;

    // Default-width request; the top re-declares it at its own widths for the FIFO.
    typedef struct packed {
        logic                     we;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    localparam logic [WB_DATA_WIDTH-1:0] RSP_ABORT_DATA = '0;

endpackage

// File: rtl/wb_request_initiator_if.sv
// wb_request_initiator_if: Wishbone B4 classic single-beat bus between initiator (master) and responder (slave).
interface wb_request_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ack_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o,
        input  data_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o,
        output data_i, ack_i
    );

endinterface

// File: rtl/wb_request_initiator_fifo.sv
// wb_req_fifo: synchronous request FIFO with full/empty flags and async active-low reset.
module wb_req_fifo
    import wb_initiator_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [PW:0]     cnt_q;

    // Callers only push when not full and pop when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q  <= pop_i ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

endmodule

// File: rtl/wb_request_initiator.sv
// wb_request_initiator: Wishbone B4 classic initiator issuing queued single-beat requests, one at a time.
// Define WB_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES cycles without ack.
module wb_request_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    wb_request_initiator_if.master wb
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUS  = BUS;
    localparam logic [1:0] ST_RESP = RESP;

    if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_request_initiator: REQ_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    logic [1:0]            state_q, state_d;
    req_t                  req_q, req_d, fifo_dout;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  pop, full, empty, timeout;

    wb_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid_i & ~full),
        .din_i   (req_t'{req_we_i, req_addr_i, req_data_i}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    // Counts completed BUS cycles; an ack in the limit cycle still wins.
    assign timeout = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) & ~wb.ack_i;
    always_comb tmo_d = (state_q == ST_BUS) ? tmo_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    req_d   = fifo_dout;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb.ack_i || timeout) begin
                    rsp_data_d = (wb.ack_i && !req_q.we) ? wb.data_i : DATA_WIDTH'(RSP_ABORT_DATA);
                    rsp_err_d  = timeout;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = rsp_ready_i ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Bus qualifiers are forced low outside a cycle so idle bus lines stay quiet.
    assign wb.cyc_o    = state_q == ST_BUS;
    assign wb.stb_o    = wb.cyc_o;
    assign wb.we_o     = wb.cyc_o & req_q.we;
    assign wb.addr_o   = wb.cyc_o ? req_q.addr : '0;
    assign wb.data_o   = wb.cyc_o ? req_q.data : '0;

    assign req_ready_o = ~full;
    assign rsp_valid_o = state_q == ST_RESP;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != ST_IDLE) | ~empty;

endmodule
